// File: rtl/ttl_93_timer_arbiter.sv
// Round-robin arbiter and synchronous 74LS93-style shared counter for two requesters.
// Grant registered at the request edge; DONE pulses one cycle after the terminal TICK; idle requests queue.
module ttl_93_timer_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TICK,
  input  logic [1:0]       REQ,
  input  logic [WIDTH-1:0] LEN0,
  input  logic [WIDTH-1:0] LEN1,
  output logic [1:0]       GNT,
  output logic [1:0]       DONE,
  output logic             BUSY,
  output logic [WIDTH-1:0] O
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_ptr, w_ptr_nxt;
  logic [1:0]       r_gnt, w_gnt_nxt;
  logic [1:0]       r_done, w_done_nxt;
  logic             r_busy, w_busy_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_len, w_len_nxt;

  logic [WIDTH-1:0] w_inc;
  logic             w_win;

  assign w_inc = r_cnt + WIDTH'(1);

  // r_ptr holds the last-granted requester, which is also the owner during RUN.
  always_comb begin
    w_win = ~r_ptr;
    if (REQ == 2'b01) w_win = 1'b0;
    else if (REQ == 2'b10) w_win = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = 2'b00;
    w_busy_nxt  = r_busy;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    case (r_state)
      S_IDLE: begin
        if (|REQ) begin
          w_state_nxt = S_RUN;
          w_ptr_nxt   = w_win;
          w_gnt_nxt   = w_win ? 2'b10 : 2'b01;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_len_nxt   = w_win ? LEN1 : LEN0;
        end
      end
      S_RUN: begin
        // Abort takes priority over a terminal tick on the same edge.
        if (!REQ[r_ptr]) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = 2'b00;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end else if (TICK) begin
          if (w_inc == r_len) begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = 2'b00;
            w_busy_nxt  = 1'b0;
            w_cnt_nxt   = '0;
            w_done_nxt  = r_gnt;
          end else begin
            w_cnt_nxt = w_inc;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b1;
      r_gnt   <= 2'b00;
      r_done  <= 2'b00;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
    end
  end

  assign GNT  = r_gnt;
  assign DONE = r_done;
  assign BUSY = r_busy;
  assign O    = r_cnt;

endmodule

// File: tb/tb_ttl_93_timer_arbiter.sv
// Directed bench for ttl_93_timer_arbiter: per-cycle expected outputs queued with the stimulus,
// popped and compared one time unit after the following rising edge.
module tb_ttl_93_timer_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       TICK;
  logic [1:0] REQ;
  logic [3:0] LEN0;
  logic [3:0] LEN1;
  logic [1:0] GNT;
  logic [1:0] DONE;
  logic       BUSY;
  logic [3:0] O;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic [3:0] o;
    string      tag;
  } exp_t;

  exp_t sb[$];

  ttl_93_timer_arbiter #(.WIDTH(4)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (TICK),
    .REQ  (REQ),
    .LEN0 (LEN0),
    .LEN1 (LEN1),
    .GNT  (GNT),
    .DONE (DONE),
    .BUSY (BUSY),
    .O    (O)
  );

  always #5 CLK = ~CLK;

  task automatic cyc(input logic rst, input logic [1:0] req, input logic tick,
                     input logic [1:0] eg, input logic [1:0] ed, input logic eb,
                     input logic [3:0] eo, input string tag);
    exp_t e;
    RST  = rst;
    REQ  = req;
    TICK = tick;
    e.gnt = eg; e.done = ed; e.busy = eb; e.o = eo; e.tag = tag;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    checks++;
    assert (GNT === e.gnt) else begin
      failures++;
      $error("FAIL %s GNT got=%b exp=%b", e.tag, GNT, e.gnt);
    end
    checks++;
    assert (DONE === e.done) else begin
      failures++;
      $error("FAIL %s DONE got=%b exp=%b", e.tag, DONE, e.done);
    end
    checks++;
    assert (BUSY === e.busy) else begin
      failures++;
      $error("FAIL %s BUSY got=%b exp=%b", e.tag, BUSY, e.busy);
    end
    checks++;
    assert (O === e.o) else begin
      failures++;
      $error("FAIL %s O got=%0d exp=%0d", e.tag, O, e.o);
    end
  endtask

  initial begin
    RST = 1'b1; REQ = 2'b00; TICK = 1'b0; LEN0 = 4'd0; LEN1 = 4'd0;
    @(negedge CLK);

    // 1: single requester, LEN0=3, tick on grant edge not counted, LEN change in RUN ignored
    cyc(1, 2'b00, 1, 2'b00, 2'b00, 0, 0, "t1_reset");
    cyc(1, 2'b00, 1, 2'b00, 2'b00, 0, 0, "t1_reset2");
    LEN0 = 4'd3;
    cyc(0, 2'b01, 1, 2'b01, 2'b00, 1, 0, "t1_grant");
    LEN0 = 4'd7;
    cyc(0, 2'b01, 1, 2'b01, 2'b00, 1, 1, "t1_o1");
    cyc(0, 2'b01, 1, 2'b01, 2'b00, 1, 2, "t1_o2");
    cyc(0, 2'b01, 1, 2'b00, 2'b01, 0, 0, "t1_done");
    cyc(0, 2'b00, 1, 2'b00, 2'b00, 0, 0, "t1_idle");

    // 2: both request from reset, requester 0 first, then 1
    cyc(1, 2'b00, 1, 2'b00, 2'b00, 0, 0, "t2_reset");
    LEN0 = 4'd2; LEN1 = 4'd5;
    cyc(0, 2'b11, 1, 2'b01, 2'b00, 1, 0, "t2_gnt0");
    cyc(0, 2'b11, 1, 2'b01, 2'b00, 1, 1, "t2_r0_o1");
    cyc(0, 2'b11, 1, 2'b00, 2'b01, 0, 0, "t2_done0");
    cyc(0, 2'b10, 1, 2'b10, 2'b00, 1, 0, "t2_gnt1");
    for (int i = 1; i < 5; i++)
      cyc(0, 2'b10, 1, 2'b10, 2'b00, 1, 4'(i), "t2_r1_cnt");
    cyc(0, 2'b10, 1, 2'b00, 2'b10, 0, 0, "t2_done1");
    cyc(0, 2'b00, 1, 2'b00, 2'b00, 0, 0, "t2_idle");

    // 3: LEN0=0 means 16 ticks, TICK every third cycle
    LEN0 = 4'd0;
    cyc(0, 2'b01, 0, 2'b01, 2'b00, 1, 0, "t3_grant");
    for (int t = 1; t <= 16; t++) begin
      cyc(0, 2'b01, 0, 2'b01, 2'b00, 1, 4'(t - 1), "t3_hold_a");
      cyc(0, 2'b01, 0, 2'b01, 2'b00, 1, 4'(t - 1), "t3_hold_b");
      if (t < 16) cyc(0, 2'b01, 1, 2'b01, 2'b00, 1, 4'(t), "t3_tick");
      else        cyc(0, 2'b01, 1, 2'b00, 2'b01, 0, 0, "t3_done");
    end
    cyc(0, 2'b00, 0, 2'b00, 2'b00, 0, 0, "t3_idle");

    // 4: abort at O=4 with LEN0=8
    LEN0 = 4'd8;
    cyc(0, 2'b01, 1, 2'b01, 2'b00, 1, 0, "t4_grant");
    for (int i = 1; i <= 4; i++)
      cyc(0, 2'b01, 1, 2'b01, 2'b00, 1, 4'(i), "t4_cnt");
    cyc(0, 2'b00, 1, 2'b00, 2'b00, 0, 0, "t4_abort");
    cyc(0, 2'b00, 1, 2'b00, 2'b00, 0, 0, "t4_nodone");

    // 5: reset mid-run; pointer returns to favour requester 0
    LEN1 = 4'd6;
    cyc(0, 2'b10, 1, 2'b10, 2'b00, 1, 0, "t5_grant1");
    for (int i = 1; i <= 3; i++)
      cyc(0, 2'b10, 1, 2'b10, 2'b00, 1, 4'(i), "t5_cnt");
    cyc(1, 2'b10, 1, 2'b00, 2'b00, 0, 0, "t5_rst");
    cyc(0, 2'b11, 1, 2'b01, 2'b00, 1, 0, "t5_gnt0");
    cyc(1, 2'b11, 1, 2'b00, 2'b00, 0, 0, "t5_rst2");
    cyc(0, 2'b11, 1, 2'b01, 2'b00, 1, 0, "t5_ptr_reset");
    cyc(0, 2'b00, 1, 2'b00, 2'b00, 0, 0, "t5_abort");

    // 6: back-to-back re-grant, then alternation at DONE
    LEN0 = 4'd2;
    cyc(0, 2'b01, 1, 2'b01, 2'b00, 1, 0, "t6_grant");
    cyc(0, 2'b01, 1, 2'b01, 2'b00, 1, 1, "t6_o1");
    cyc(0, 2'b01, 1, 2'b00, 2'b01, 0, 0, "t6_done");
    cyc(0, 2'b01, 1, 2'b01, 2'b00, 1, 0, "t6_regrant");
    cyc(0, 2'b01, 1, 2'b01, 2'b00, 1, 1, "t6_o1b");
    cyc(0, 2'b11, 1, 2'b00, 2'b01, 0, 0, "t6_done2");
    cyc(0, 2'b11, 1, 2'b10, 2'b00, 1, 0, "t6_alt1");
    cyc(0, 2'b00, 1, 2'b00, 2'b00, 0, 0, "t6_abort1");

    // abort on the terminal edge suppresses DONE
    LEN0 = 4'd1;
    cyc(0, 2'b01, 1, 2'b01, 2'b00, 1, 0, "t7_grant");
    cyc(0, 2'b00, 1, 2'b00, 2'b00, 0, 0, "t7_abort_term");
    cyc(0, 2'b00, 1, 2'b00, 2'b00, 0, 0, "t7_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
